// File: rtl/bus_register_bank_pkg.sv
// Shared definitions for the basic-computer bus: register indices, bus select
// codes and default datapath widths. Used by the register bank, bus mux and control unit.
package bus_register_bank_pkg;

  localparam int unsigned ADDR_W_DEF = 12;
  localparam int unsigned DATA_W_DEF = 16;

  localparam int unsigned NUM_REGS = 6;
  localparam int unsigned REG_AR   = 0;
  localparam int unsigned REG_PC   = 1;
  localparam int unsigned REG_DR   = 2;
  localparam int unsigned REG_AC   = 3;
  localparam int unsigned REG_IR   = 4;
  localparam int unsigned REG_TR   = 5;

  typedef enum logic [2:0] {
    BUS_NONE = 3'd0,
    BUS_AR   = 3'd1,
    BUS_PC   = 3'd2,
    BUS_DR   = 3'd3,
    BUS_AC   = 3'd4,
    BUS_IR   = 3'd5,
    BUS_TR   = 3'd6,
    BUS_MEM  = 3'd7
  } bus_code_e;

  // Registers whose load data comes from the bus (everything except AC).
  localparam logic [NUM_REGS-1:0] BUS_LD_MASK = 6'b110111;

endpackage

// File: rtl/bus_register_bank_ctl_register.sv
// Generic control register: clear beats load beats increment beats hold,
// synchronous active-low reset to zero.
module ctl_register #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             ld,
  input  logic             inr,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;

  always_comb begin
    q_d = q_q;
    if (clr) begin
      q_d = '0;
    end else if (ld) begin
      q_d = d;
    end else if (inr) begin
      q_d = q_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/bus_register_bank.sv
// Destination side of the common bus: AR, PC, DR, AC, IR, TR, the sequence
// counter with its one-hot timing decode, and a sticky illegal-load flag.
module bus_register_bank
  import bus_register_bank_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned SC_W   = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [DATA_W-1:0]    bus_data,
  input  logic [DATA_W-1:0]    ac_indata,
  input  logic [2:0]           buscode,
  input  logic [5:0]           ld,
  input  logic [5:0]           inr,
  input  logic [5:0]           clr,
  input  logic                 sc_inr,
  input  logic                 sc_clr,
  output logic [ADDR_W-1:0]    ar_outdata,
  output logic [ADDR_W-1:0]    pc_outdata,
  output logic [DATA_W-1:0]    dr_outdata,
  output logic [DATA_W-1:0]    ac_outdata,
  output logic [DATA_W-1:0]    ir_outdata,
  output logic [DATA_W-1:0]    tr_outdata,
  output logic [SC_W-1:0]      t_state,
  output logic [2**SC_W-1:0]   t_onehot,
  output logic                 bus_err
);

  localparam int unsigned      T_W        = 2**SC_W;
  localparam logic [T_W-1:0]   ONEHOT_RST = {{(T_W-1){1'b0}}, 1'b1};

  logic                illegal;
  logic [5:0]          ld_eff;
  logic                bus_err_q, bus_err_d;
  logic [SC_W-1:0]     sc_q, sc_d;
  logic [T_W-1:0]      t_onehot_q, t_onehot_d;

  // An invalid bus code blocks loads of bus-fed registers; AC is fed by the ALU.
  always_comb begin
    illegal   = (buscode == BUS_NONE);
    ld_eff    = ld;
    bus_err_d = bus_err_q;
    if (illegal) begin
      ld_eff = ld & ~BUS_LD_MASK;
      if ((ld & BUS_LD_MASK) != '0) begin
        bus_err_d = 1'b1;
      end
    end
  end

  // The one-hot decode is taken from the next SC value so both flops agree.
  always_comb begin
    sc_d = sc_q;
    if (sc_clr) begin
      sc_d = '0;
    end else if (sc_inr) begin
      sc_d = sc_q + SC_W'(1);
    end
    t_onehot_d       = '0;
    t_onehot_d[sc_d] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bus_err_q  <= 1'b0;
      sc_q       <= '0;
      t_onehot_q <= ONEHOT_RST;
    end else begin
      bus_err_q  <= bus_err_d;
      sc_q       <= sc_d;
      t_onehot_q <= t_onehot_d;
    end
  end

  ctl_register #(.WIDTH(ADDR_W)) u_ar (
    .clk(clk), .rst_n(rst_n), .clr(clr[REG_AR]), .ld(ld_eff[REG_AR]), .inr(inr[REG_AR]),
    .d(bus_data[ADDR_W-1:0]), .q(ar_outdata)
  );

  ctl_register #(.WIDTH(ADDR_W)) u_pc (
    .clk(clk), .rst_n(rst_n), .clr(clr[REG_PC]), .ld(ld_eff[REG_PC]), .inr(inr[REG_PC]),
    .d(bus_data[ADDR_W-1:0]), .q(pc_outdata)
  );

  ctl_register #(.WIDTH(DATA_W)) u_dr (
    .clk(clk), .rst_n(rst_n), .clr(clr[REG_DR]), .ld(ld_eff[REG_DR]), .inr(inr[REG_DR]),
    .d(bus_data), .q(dr_outdata)
  );

  ctl_register #(.WIDTH(DATA_W)) u_ac (
    .clk(clk), .rst_n(rst_n), .clr(clr[REG_AC]), .ld(ld_eff[REG_AC]), .inr(inr[REG_AC]),
    .d(ac_indata), .q(ac_outdata)
  );

  ctl_register #(.WIDTH(DATA_W)) u_ir (
    .clk(clk), .rst_n(rst_n), .clr(clr[REG_IR]), .ld(ld_eff[REG_IR]), .inr(inr[REG_IR]),
    .d(bus_data), .q(ir_outdata)
  );

  ctl_register #(.WIDTH(DATA_W)) u_tr (
    .clk(clk), .rst_n(rst_n), .clr(clr[REG_TR]), .ld(ld_eff[REG_TR]), .inr(inr[REG_TR]),
    .d(bus_data), .q(tr_outdata)
  );

  assign t_state  = sc_q;
  assign t_onehot = t_onehot_q;
  assign bus_err  = bus_err_q;

endmodule

// File: tb/tb_bus_register_bank.sv
// Bench for bus_register_bank: directed scenarios plus randomized strobes with
// the bus fed back from the modelled registers, compared every cycle.
module tb_bus_register_bank;
  import bus_register_bank_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] bus_data, ac_indata;
  logic [2:0]  buscode;
  logic [5:0]  ld, inr, clr;
  logic        sc_inr, sc_clr;
  logic [11:0] ar_outdata, pc_outdata;
  logic [15:0] dr_outdata, ac_outdata, ir_outdata, tr_outdata;
  logic [3:0]  t_state;
  logic [15:0] t_onehot;
  logic        bus_err;

  int unsigned errors = 0;
  int unsigned checks = 0;

  // Behavioural model state
  int unsigned m_reg [6];
  int unsigned m_sc;
  bit          m_err;

  always #5 clk = ~clk;

  bus_register_bank #(.ADDR_W(12), .DATA_W(16), .SC_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .bus_data(bus_data), .ac_indata(ac_indata),
    .buscode(buscode), .ld(ld), .inr(inr), .clr(clr), .sc_inr(sc_inr), .sc_clr(sc_clr),
    .ar_outdata(ar_outdata), .pc_outdata(pc_outdata), .dr_outdata(dr_outdata),
    .ac_outdata(ac_outdata), .ir_outdata(ir_outdata), .tr_outdata(tr_outdata),
    .t_state(t_state), .t_onehot(t_onehot), .bus_err(bus_err)
  );

  function automatic int unsigned reg_mod(int unsigned i);
    return (i == REG_AR || i == REG_PC) ? 32'h1000 : 32'h10000;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Advance the model by one rising edge using the inputs currently applied.
  task automatic model_edge();
    if (!rst_n) begin
      foreach (m_reg[i]) m_reg[i] = 0;
      m_sc  = 0;
      m_err = 1'b0;
      return;
    end
    for (int i = 0; i < 6; i++) begin
      bit bus_fed = (i != REG_AC);
      if (clr[i]) m_reg[i] = 0;
      else if (ld[i] && !(bus_fed && buscode == 3'd0))
        m_reg[i] = (bus_fed ? int'(bus_data) : int'(ac_indata)) % reg_mod(i);
      else if (inr[i]) m_reg[i] = (m_reg[i] + 1) % reg_mod(i);
      if (ld[i] && bus_fed && buscode == 3'd0) m_err = 1'b1;
    end
    if (sc_clr) m_sc = 0;
    else if (sc_inr) m_sc = (m_sc + 1) % 16;
  endtask

  task automatic compare_all();
    check("ar", 32'(ar_outdata), m_reg[REG_AR]);
    check("pc", 32'(pc_outdata), m_reg[REG_PC]);
    check("dr", 32'(dr_outdata), m_reg[REG_DR]);
    check("ac", 32'(ac_outdata), m_reg[REG_AC]);
    check("ir", 32'(ir_outdata), m_reg[REG_IR]);
    check("tr", 32'(tr_outdata), m_reg[REG_TR]);
    check("t_state", 32'(t_state), m_sc);
    check("t_onehot", 32'(t_onehot), 32'h1 << m_sc);
    check("bus_err", 32'(bus_err), 32'(m_err));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    model_edge();
    compare_all();
  endtask

  task automatic idle();
    rst_n = 1'b1; ld = '0; inr = '0; clr = '0; sc_inr = 1'b0; sc_clr = 1'b0;
    buscode = BUS_MEM; bus_data = '0; ac_indata = '0;
  endtask

  function automatic logic [15:0] bus_source(logic [2:0] code);
    case (code)
      3'd1: return 16'(m_reg[REG_AR]);
      3'd2: return 16'(m_reg[REG_PC]);
      3'd3: return 16'(m_reg[REG_DR]);
      3'd4: return 16'(m_reg[REG_AC]);
      3'd5: return 16'(m_reg[REG_IR]);
      3'd6: return 16'(m_reg[REG_TR]);
      default: return 16'($urandom);
    endcase
  endfunction

  initial begin
    foreach (m_reg[i]) m_reg[i] = 0;
    m_sc = 0; m_err = 1'b0;
    idle();
    rst_n = 1'b0;
    step();

    // 1: load nonzero values, then reset clears everything
    idle(); ld = 6'h3F; bus_data = 16'hBEEF; ac_indata = 16'h1234; sc_inr = 1'b1;
    step();
    check("pre_reset_dr", 32'(dr_outdata), 32'hBEEF);
    idle(); rst_n = 1'b0; ld = 6'h3F; inr = 6'h3F; sc_inr = 1'b1; bus_data = 16'h1111;
    step();
    check("reset_onehot", 32'(t_onehot), 32'h0001);
    check("reset_ac", 32'(ac_outdata), 32'h0);

    // 2: fetch AR <- PC over the bus
    idle(); buscode = BUS_PC; bus_data = 16'hA123; ld[REG_AR] = 1'b1;
    step();
    check("fetch_ar", 32'(ar_outdata), 32'h123);

    // 3: priority on DR
    idle(); bus_data = 16'h5555; clr[REG_DR] = 1'b1; ld[REG_DR] = 1'b1; inr[REG_DR] = 1'b1;
    step();
    check("prio_clr", 32'(dr_outdata), 32'h0);
    clr = '0;
    step();
    check("prio_ld", 32'(dr_outdata), 32'h5555);
    ld = '0;
    step();
    check("prio_inr", 32'(dr_outdata), 32'h5556);

    // 4: wraps
    idle(); bus_data = 16'hFFFF; ld[REG_PC] = 1'b1; ld[REG_TR] = 1'b1;
    step();
    check("pc_full", 32'(pc_outdata), 32'hFFF);
    idle(); inr[REG_PC] = 1'b1; inr[REG_TR] = 1'b1;
    step();
    check("pc_wrap", 32'(pc_outdata), 32'h0);
    check("tr_wrap", 32'(tr_outdata), 32'h0);
    idle(); sc_clr = 1'b1;
    step();
    sc_clr = 1'b0; sc_inr = 1'b1;
    for (int i = 0; i < 15; i++) step();
    check("sc_15", 32'(t_state), 32'd15);
    check("onehot_15", 32'(t_onehot), 32'h8000);
    step();
    check("sc_wrap", 32'(t_state), 32'd0);
    check("onehot_wrap", 32'(t_onehot), 32'h0001);

    // 5: illegal bus code
    idle(); bus_data = 16'h3C3C; ld[REG_IR] = 1'b1;
    step();
    idle(); buscode = 3'd0; bus_data = 16'h7777; ld[REG_IR] = 1'b1; ld[REG_AC] = 1'b1;
    ac_indata = 16'h0042;
    step();
    check("illegal_ir", 32'(ir_outdata), 32'h3C3C);
    check("illegal_ac", 32'(ac_outdata), 32'h0042);
    check("illegal_err", 32'(bus_err), 32'h1);
    idle();
    for (int i = 0; i < 10; i++) begin
      step();
      check("err_sticky", 32'(bus_err), 32'h1);
    end
    rst_n = 1'b0;
    step();
    check("err_cleared", 32'(bus_err), 32'h0);

    // 6: reset wins over simultaneous strobes
    idle(); bus_data = 16'h9999; ld[REG_DR] = 1'b1; sc_inr = 1'b1;
    step();
    rst_n = 1'b0; bus_data = 16'h4321;
    step();
    check("mid_reset_dr", 32'(dr_outdata), 32'h0);
    check("mid_reset_sc", 32'(t_state), 32'h0);

    // Randomized: bus fed from modelled register sources to exercise self-loops
    for (int n = 0; n < 3000; n++) begin
      logic [2:0] code;
      code      = 3'($urandom_range(0, 7));
      rst_n     = ($urandom_range(0, 99) != 0);
      buscode   = code;
      bus_data  = bus_source(code);
      ac_indata = 16'($urandom);
      ld        = 6'($urandom) & 6'($urandom);
      inr       = 6'($urandom) & 6'($urandom);
      clr       = 6'($urandom) & 6'($urandom) & 6'($urandom);
      sc_inr    = $urandom_range(0, 2) != 0;
      sc_clr    = $urandom_range(0, 9) == 0;
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
